// File: rtl/fetch_unit.sv
// Fetch stage producer: generates the fetch PC, drives the synchronous imem read and presents
// (pc, instr, valid) to the fetch buffer. Defining FETCH_PERF_CNT_EN adds fetch/stall counters.
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    PC_STEP     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   imem_rd_en,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   valid_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            fetch_count,
    output logic [31:0]            stall_count
`endif
);

    localparam logic [ADDR_WIDTH-1:0] L_PC_STEP = ADDR_WIDTH'(PC_STEP);

    logic                   r_run;
    logic [ADDR_WIDTH-1:0]  r_fetch_pc;
    logic                   r_req_vld;
    logic [ADDR_WIDTH-1:0]  r_req_pc;
    logic                   r_sk_vld;
    logic [ADDR_WIDTH-1:0]  r_sk_pc;
    logic [INSTR_WIDTH-1:0] r_sk_instr;
    logic                   r_valid_out;
    logic [ADDR_WIDTH-1:0]  r_pc_out;
    logic [INSTR_WIDTH-1:0] r_instr_out;

    logic w_advance;
    logic w_issue;

    // The output slot may change only when neither stalled nor redirected; reads follow the same gate.
    assign w_advance  = ~stall & ~redirect_valid;
    assign w_issue    = r_run & w_advance;

    assign imem_rd_en = w_issue;
    assign imem_addr  = r_fetch_pc;
    assign pc_out     = r_pc_out;
    assign instr_out  = r_instr_out;
    assign valid_out  = r_valid_out;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_req_vld  <= 1'b0;
            r_req_pc   <= '0;
        end else begin
            r_run <= 1'b1;
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
                r_req_vld  <= 1'b0;
            end else begin
                r_req_vld <= w_issue;
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + L_PC_STEP;
                    r_req_pc   <= r_fetch_pc;
                end
            end
        end
    end

    // Stall blocks issue, so a stall episode sees at most one arrival and the skid cannot overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sk_vld    <= 1'b0;
            r_sk_pc     <= '0;
            r_sk_instr  <= '0;
            r_valid_out <= 1'b0;
            r_pc_out    <= '0;
            r_instr_out <= '0;
        end else if (redirect_valid) begin
            r_sk_vld    <= 1'b0;
            r_valid_out <= 1'b0;
        end else if (stall) begin
            if (r_req_vld) begin
                r_sk_vld   <= 1'b1;
                r_sk_pc    <= r_req_pc;
                r_sk_instr <= imem_rdata;
            end
        end else if (r_sk_vld) begin
            r_sk_vld    <= 1'b0;
            r_valid_out <= 1'b1;
            r_pc_out    <= r_sk_pc;
            r_instr_out <= r_sk_instr;
        end else if (r_req_vld) begin
            r_valid_out <= 1'b1;
            r_pc_out    <= r_req_pc;
            r_instr_out <= imem_rdata;
        end else begin
            r_valid_out <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (r_valid_out && w_advance && (r_fetch_count != '1)) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (r_valid_out && stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

endmodule
